// File: rtl/cheat_pkg.sv
// Shared state encoding, record layout and helpers for the cheat loader.
// Defining CHEAT_LOADER_CHECKSUM_EN appends a checksum byte to every record.
package cheat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        WRITE,
        WAIT_ACK,
        DONE
    } cheat_state_t;

    localparam int REC_W      = 128;
    localparam int DATA_BYTES = REC_W / 8;

    localparam int SLOT_HI    = 111;
    localparam int SLOT_LO    = 104;
    localparam int CMP_EN_BIT = 96;
    localparam int ADDR_HI    = 79;
    localparam int ADDR_LO    = 64;
    localparam int CMP_HI     = 39;
    localparam int CMP_LO     = 32;
    localparam int REPL_HI    = 7;
    localparam int REPL_LO    = 0;

    localparam logic [1:0] CHEAT_WB_ADDR_DATA = 2'h1;

`ifdef CHEAT_LOADER_CHECKSUM_EN
    localparam int CHEAT_REC_BYTES = DATA_BYTES + 1;
`else
    localparam int CHEAT_REC_BYTES = DATA_BYTES;
`endif

    localparam int IDX_W = $clog2(CHEAT_REC_BYTES + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cheat_rec_assembler.sv
// Byte-to-record shift register with byte index and, under
// CHEAT_LOADER_CHECKSUM_EN, a running modulo-256 sum of the record bytes.
module cheat_rec_assembler
    import cheat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             take,
    input  logic [7:0]       data_byte,
    output logic [REC_W-1:0] rec,
    output logic             held,
    output logic             last,
    output logic             sum_ok
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHEAT_REC_BYTES - 1);
    localparam logic [IDX_W-1:0] DATA_END = IDX_W'(DATA_BYTES);

    logic [IDX_W-1:0] idx;

    assign held = (idx != '0);
    assign last = take && (idx == LAST_IDX);

    // Record contents survive a clear so the bus write can still present them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            rec <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (take) begin
            idx <= idx + 1'b1;
            if (idx < DATA_END)
                rec <= {rec[REC_W-9:0], data_byte};
        end
    end

`ifdef CHEAT_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum <= 8'h00;
        else if (clear)
            sum <= 8'h00;
        else if (take)
            sum <= sum + data_byte;
    end

    assign sum_ok = (sum == 8'h00);
`else
    assign sum_ok = 1'b1;
`endif

endmodule

// File: rtl/cheat_loader.sv
// Collects cheat records from a byte stream, validates them and writes each
// accepted record over Wishbone. Optional checksum: CHEAT_LOADER_CHECKSUM_EN.
module cheat_loader
    import cheat_pkg::*;
#(
    parameter int MAX_CHEATS = 4,
    parameter int WB_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load_start,
    input  logic         i_load_end,
    input  logic         i_byte_valid,
    input  logic [7:0]   i_byte,
    output logic         o_byte_ready,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    output logic         o_wb_we,
    output logic [1:0]   o_wb_addr,
    output logic [128:0] o_wb_data,
    input  logic         i_wb_ack,
    input  logic         i_wb_stall,
    input  logic         i_wb_err,
    output logic         o_cheats_loaded,
    output logic [7:0]   o_cheat_count,
    output logic [7:0]   o_reject_count,
    output logic         o_busy
);

    localparam int TMO_W = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WB_TIMEOUT - 1);

    cheat_state_t     state, next;
    logic [REC_W-1:0] rec;
    logic             take, held, last, sum_ok, slot_ok;
    logic             asm_clear, cheat_inc, rej_inc, end_pending;
    logic [7:0]       slot;
    logic [TMO_W-1:0] timer;
    cheat_state_t     after;

    cheat_rec_assembler u_asm (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (asm_clear),
        .take      (take),
        .data_byte (i_byte),
        .rec       (rec),
        .held      (held),
        .last      (last),
        .sum_ok    (sum_ok)
    );

    assign take    = o_byte_ready && i_byte_valid;
    assign slot    = rec[SLOT_HI:SLOT_LO];
    assign slot_ok = (slot != 8'd0) && (int'(slot) <= MAX_CHEATS);

    // A stop request seen mid-record takes effect once that record resolves.
    assign after = (end_pending || i_load_end) ? DONE : COLLECT;

    always_comb begin
        next      = state;
        asm_clear = 1'b0;
        cheat_inc = 1'b0;
        rej_inc   = 1'b0;
        case (state)
            COLLECT: begin
                if (i_load_end) begin
                    next      = DONE;
                    asm_clear = 1'b1;
                    rej_inc   = held || take;
                end else if (last) begin
                    next = CHECK;
                end
            end
            CHECK: begin
                asm_clear = 1'b1;
                if (slot_ok && sum_ok) begin
                    next = WRITE;
                end else begin
                    rej_inc = 1'b1;
                    next    = after;
                end
            end
            WRITE: begin
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        cheat_inc = 1'b1;
                        next      = after;
                    end else if (i_wb_err) begin
                        rej_inc = 1'b1;
                        next    = after;
                    end else begin
                        next = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (i_wb_ack) begin
                    cheat_inc = 1'b1;
                    next      = after;
                end else if (i_wb_err || timer == TMO_LAST) begin
                    rej_inc = 1'b1;
                    next    = after;
                end
            end
            default: ;
        endcase
        if (i_load_start) begin
            next      = COLLECT;
            asm_clear = 1'b1;
            cheat_inc = 1'b0;
            rej_inc   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            timer <= '0;
        else if (state != WAIT_ACK)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            end_pending <= 1'b0;
        else if (i_load_start || state == DONE)
            end_pending <= 1'b0;
        else if (i_load_end && o_busy)
            end_pending <= 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cheat_count  <= 8'h00;
            o_reject_count <= 8'h00;
        end else if (i_load_start) begin
            o_cheat_count  <= 8'h00;
            o_reject_count <= 8'h00;
        end else begin
            if (cheat_inc)
                o_cheat_count <= sat_inc(o_cheat_count);
            if (rej_inc)
                o_reject_count <= sat_inc(o_reject_count);
        end
    end

    // Bus outputs decode straight from state so reset drops them at once.
    assign o_byte_ready    = (state == COLLECT);
    assign o_busy          = (state == CHECK) || (state == WRITE) || (state == WAIT_ACK);
    assign o_cheats_loaded = (state == DONE);
    assign o_wb_cyc        = (state == WRITE) || (state == WAIT_ACK);
    assign o_wb_stb        = (state == WRITE);
    assign o_wb_we         = (state == WRITE);
    assign o_wb_addr       = (state == WRITE) ? CHEAT_WB_ADDR_DATA : 2'h0;
    assign o_wb_data       = (state == WRITE) ? {1'b0, rec} : '0;

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: directed corner sequences, a vector table and a
// randomized run scored against a record-level model of load outcomes.
`timescale 1ns/1ps
module tb_cheat_loader;
    import cheat_pkg::*;

    localparam int MAXC   = 4;
    localparam int TMO    = 255;
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;

    logic         i_clk = 1'b0;
    logic         i_reset, i_load_start, i_load_end, i_byte_valid;
    logic [7:0]   i_byte;
    logic         o_byte_ready, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [1:0]   o_wb_addr;
    logic [128:0] o_wb_data;
    logic         i_wb_ack, i_wb_stall, i_wb_err;
    logic         o_cheats_loaded, o_busy;
    logic [7:0]   o_cheat_count, o_reject_count;

    cheat_loader #(.MAX_CHEATS(MAXC), .WB_TIMEOUT(TMO)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_load_start    (i_load_start),
        .i_load_end      (i_load_end),
        .i_byte_valid    (i_byte_valid),
        .i_byte          (i_byte),
        .o_byte_ready    (o_byte_ready),
        .o_wb_cyc        (o_wb_cyc),
        .o_wb_stb        (o_wb_stb),
        .o_wb_we         (o_wb_we),
        .o_wb_addr       (o_wb_addr),
        .o_wb_data       (o_wb_data),
        .i_wb_ack        (i_wb_ack),
        .i_wb_stall      (i_wb_stall),
        .i_wb_err        (i_wb_err),
        .o_cheats_loaded (o_cheats_loaded),
        .o_cheat_count   (o_cheat_count),
        .o_reject_count  (o_reject_count),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   rb [DATA_BYTES];
    logic [128:0] last_data;

    typedef struct {
        logic [7:0] slot;
        int         stall;
        int         ack_lat;
        int         mode;
        bit         exp_bus;
        int         exp_dc;
        int         exp_dr;
    } vec_t;

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
    endtask

    task automatic pulse_end();
        i_load_end = 1'b1;
        step();
        i_load_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (!o_byte_ready && n < 20) begin
            step();
            n++;
        end
        if (!o_byte_ready)
            chk("byte_ready_timeout", 1'b0, 1'b1);
        step();
        i_byte_valid = 1'b0;
    endtask

    task automatic send_record();
`ifdef CHEAT_LOADER_CHECKSUM_EN
        logic [7:0] s = 8'h00;
`endif
        for (int k = 0; k < DATA_BYTES; k++)
            send_byte(rb[k]);
`ifdef CHEAT_LOADER_CHECKSUM_EN
        for (int k = 0; k < DATA_BYTES; k++)
            s = s + rb[k];
        send_byte(8'h00 - s);
`endif
    endtask

    // Byte k of the stream lands at bits [127-8k -: 8] of the record.
    function automatic logic [127:0] rec_of();
        logic [127:0] r = '0;
        for (int k = 0; k < DATA_BYTES; k++)
            r[REC_W-1-8*k -: 8] = rb[k];
        return r;
    endfunction

    task automatic make_rec(input logic [7:0] slot);
        for (int k = 0; k < DATA_BYTES; k++)
            rb[k] = 8'($urandom);
        rb[(REC_W-1-SLOT_HI)/8] = slot;
    endtask

    task automatic serve(input int stall_n, input int ack_lat, input int mode, input logic [127:0] exp);
        int n      = 0;
        int stb_n  = 0;
        bit stable = 1'b1;
        while (!o_wb_stb && n < 10) begin
            step();
            n++;
        end
        chk("stb_seen", o_wb_stb, 1'b1);
        last_data = o_wb_data;
        chk("wb_addr", o_wb_addr, CHEAT_WB_ADDR_DATA);
        chk("wb_we_cyc", {o_wb_we, o_wb_cyc}, 2'b11);
        chk("wb_data", o_wb_data, {1'b0, exp});
        i_wb_stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            stb_n += int'(o_wb_stb);
            stable &= (o_wb_data === {1'b0, exp}) && o_wb_cyc && o_wb_we;
            step();
        end
        stb_n += int'(o_wb_stb);
        stable &= (o_wb_data === {1'b0, exp}) && o_wb_cyc && o_wb_we;
        chk("stb_cycles", stb_n, stall_n + 1);
        chk("stall_stable", stable, 1'b1);
        i_wb_stall = 1'b0;
        i_wb_ack   = (ack_lat == 0 && mode == M_ACK);
        i_wb_err   = (ack_lat == 0 && mode == M_ERR);
        step();
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (ack_lat == 0 && mode != M_NONE) begin
            chk("cyc_drop_on_accept", o_wb_cyc, 1'b0);
        end else begin
            chk("wait_ack_state", {o_wb_cyc, o_wb_stb, o_busy}, 3'b101);
            if (mode == M_NONE) begin
                n = 0;
                while (o_wb_cyc && n < 400) begin
                    n++;
                    step();
                end
                chk("timeout_cycles", n, TMO);
            end else begin
                for (int i = 1; i < ack_lat; i++)
                    step();
                i_wb_ack = (mode == M_ACK);
                i_wb_err = (mode == M_ERR);
                step();
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
                chk("cyc_drop_on_resp", o_wb_cyc, 1'b0);
            end
        end
    endtask

    task automatic run_record(input logic [7:0] slot, input int stall_n, input int ack_lat,
                              input int mode, input bit exp_bus);
        bit saw = 1'b0;
        make_rec(slot);
        send_record();
        if (exp_bus) begin
            serve(stall_n, ack_lat, mode, rec_of());
        end else begin
            for (int i = 0; i < 4; i++) begin
                saw |= o_wb_cyc;
                step();
            end
            chk("no_bus_cycle", saw, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [6];
        logic [7:0] c0, r0;
        logic [7:0] slots [8];
        int         exp_c, exp_r, mode, lat;
        logic [7:0] sl;
        bit         acc;

        i_reset = 1'b1; i_load_start = 1'b0; i_load_end = 1'b0;
        i_byte_valid = 1'b0; i_byte = 8'h00;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0;
        step();
        step();
        chk("rst_ctrl", {o_byte_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_cheats_loaded, o_busy}, 6'b0);
        chk("rst_addr", o_wb_addr, 2'h0);
        chk("rst_data", o_wb_data, '0);
        chk("rst_counts", {o_cheat_count, o_reject_count}, 16'h0);
        i_reset = 1'b0;
        step();
        chk("idle_no_ready", o_byte_ready, 1'b0);

        // Single good record acked one cycle after acceptance.
        pulse_start();
        chk("collect_ready", {o_byte_ready, o_busy, o_cheats_loaded}, 3'b100);
        rb = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h00, 8'h00, 8'h00, 8'hD6, 8'h00, 8'h00, 8'h00, 8'h24};
        send_record();
        chk("check_busy", {o_busy, o_byte_ready}, 2'b10);
        serve(0, 1, M_ACK, rec_of());
        chk("f_slot", last_data[SLOT_HI:SLOT_LO], 8'h01);
        chk("f_cmp_en", last_data[CMP_EN_BIT], 1'b1);
        chk("f_addr", last_data[ADDR_HI:ADDR_LO], 16'h0001);
        chk("f_cmp", last_data[CMP_HI:CMP_LO], 8'hD6);
        chk("f_repl", last_data[REPL_HI:REPL_LO], 8'h24);
        chk("f_bit128", last_data[128], 1'b0);
        pulse_end();
        chk("done_loaded", {o_cheats_loaded, o_byte_ready, o_busy}, 3'b100);
        chk("done_counts", {o_cheat_count, o_reject_count}, {8'd1, 8'd0});
        step();
        step();
        chk("done_sticky", o_cheats_loaded, 1'b1);

        // Out-of-range slot index.
        pulse_start();
        chk("start_clears", {o_cheat_count, o_reject_count, 7'b0, o_cheats_loaded}, 24'h0);
        run_record(8'd5, 0, 0, M_ACK, 1'b0);
        chk("bad_slot_counts", {o_cheat_count, o_reject_count}, {8'd0, 8'd1});
        chk("bad_slot_back_collect", o_byte_ready, 1'b1);

        // Stall three cycles, ack together with acceptance.
        pulse_start();
        run_record(8'd1, 3, 0, M_ACK, 1'b1);
        chk("stall_ack_count", o_cheat_count, 8'd1);

        // Error in WAIT_ACK, then a timeout on the following record.
        pulse_start();
        run_record(8'd2, 0, 1, M_ERR, 1'b1);
        run_record(8'd3, 0, 0, M_NONE, 1'b1);
        chk("err_tmo_counts", {o_cheat_count, o_reject_count}, {8'd0, 8'd2});

        // End after a partial record, then restart.
        pulse_start();
        for (int k = 0; k < 7; k++)
            send_byte(8'(k + 3));
        pulse_end();
        chk("partial_done", {o_cheats_loaded, o_byte_ready}, 2'b10);
        chk("partial_reject", o_reject_count, 8'd1);
        pulse_start();
        chk("restart_state", {o_cheat_count, o_reject_count, 6'b0, o_cheats_loaded, o_byte_ready},
            24'h000001);

        // End request raised during WRITE completes the record first.
        pulse_start();
        make_rec(8'd1);
        send_record();
        step();
        i_wb_stall = 1'b1;
        i_load_end = 1'b1;
        step();
        i_load_end = 1'b0;
        chk("end_latched_write", {o_wb_stb, o_cheats_loaded}, 2'b10);
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b1;
        step();
        i_wb_ack = 1'b0;
        chk("end_latched_done", {o_cheats_loaded, o_wb_cyc}, 2'b10);
        chk("end_latched_count", o_cheat_count, 8'd1);

        // Reset while a stalled strobe is outstanding.
        pulse_start();
        make_rec(8'd1);
        send_record();
        step();
        i_wb_stall = 1'b1;
        step();
        step();
        chk("pre_reset_stb", o_wb_stb, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("reset_drops_bus", {o_wb_stb, o_wb_cyc, o_wb_we, o_busy, o_byte_ready, o_cheats_loaded}, 6'b0);
        chk("reset_data", o_wb_data, '0);
        @(posedge i_clk);
        #1;
        i_reset    = 1'b0;
        i_wb_stall = 1'b0;
        step();
        step();
        chk("no_retry_after_reset", {o_wb_cyc, o_byte_ready, o_cheat_count, o_reject_count}, 18'h0);

        // Vector table.
        tbl[0] = '{8'd1,   0, 0, M_ACK, 1'b1, 1, 0};
        tbl[1] = '{8'd4,   2, 2, M_ACK, 1'b1, 1, 0};
        tbl[2] = '{8'd0,   0, 0, M_ACK, 1'b0, 0, 1};
        tbl[3] = '{8'd5,   0, 0, M_ACK, 1'b0, 0, 1};
        tbl[4] = '{8'd3,   1, 3, M_ERR, 1'b1, 0, 1};
        tbl[5] = '{8'd255, 0, 0, M_ACK, 1'b0, 0, 1};
        pulse_start();
        for (int v = 0; v < 6; v++) begin
            c0 = o_cheat_count;
            r0 = o_reject_count;
            run_record(tbl[v].slot, tbl[v].stall, tbl[v].ack_lat, tbl[v].mode, tbl[v].exp_bus);
            chk($sformatf("tbl%0d_cheat", v), o_cheat_count - c0, 8'(tbl[v].exp_dc));
            chk($sformatf("tbl%0d_reject", v), o_reject_count - r0, 8'(tbl[v].exp_dr));
        end

        // Randomized records against the outcome model.
        slots = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd255};
        pulse_start();
        exp_c = 0;
        exp_r = 0;
        for (int t = 0; t < 25; t++) begin
            sl   = slots[$urandom_range(0, 7)];
            mode = ($urandom_range(0, 3) == 0) ? M_ERR : M_ACK;
            lat  = (mode == M_ERR) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            acc  = (sl >= 8'd1) && (int'(sl) <= MAXC);
            run_record(sl, int'($urandom_range(0, 2)), lat, mode, acc);
            if (acc && mode == M_ACK)
                exp_c = (exp_c < 255) ? exp_c + 1 : 255;
            else
                exp_r = (exp_r < 255) ? exp_r + 1 : 255;
            chk($sformatf("rand%0d_counts", t), {o_cheat_count, o_reject_count},
                {8'(exp_c), 8'(exp_r)});
        end
        pulse_end();
        chk("rand_done", o_cheats_loaded, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
